// File: rtl/serial_pkg.sv
// Shared definitions for the single-bit serial link: frame state encoding,
// line-level constants and the width helper used by transmitter and receiver.
package serial_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_e;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    // Ceiling log2; returns 0 for values of 0 or 1.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each
// bit. Held at zero while clear is high so a new bit always starts a full period.
module bit_timer
    import serial_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int TW = (clog2(CLKS_PER_BIT) > 1) ? clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0] LAST_CNT = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] CNT_ONE  = TW'(32'd1);

    logic [TW-1:0] cnt_q;
    logic [TW-1:0] cnt_d;

    // Next count: hold at zero when cleared, wrap at the end of a bit period.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (cnt_q == LAST_CNT) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = !clear && (cnt_q == LAST_CNT);

endmodule

// File: rtl/piso_serial_tx.sv
// Framed parallel-in serial-out transmitter: start bit, DATA_W data bits LSB
// first, stop bit, each held CLKS_PER_BIT cycles. All outputs are registered.
module piso_serial_tx
    import serial_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    output logic              din_ready,
    output logic              sout,
    output logic              busy,
    output logic              done
);

    localparam int BW = clog2(DATA_W);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);
    localparam logic [BW-1:0] BIT_ONE  = BW'(32'd1);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [BW-1:0]     bitcnt_q, bitcnt_d;
    logic              sout_q, sout_d;
    logic              ready_q, ready_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              tick_s;
    logic              timer_clear_s;

    assign timer_clear_s = (state_q == IDLE);

    bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk  (clk),
        .rst  (rst),
        .clear(timer_clear_s),
        .tick (tick_s)
    );

    // Frame sequencing; every output is computed one cycle ahead and registered.
    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        bitcnt_d = bitcnt_q;
        sout_d   = sout_q;
        ready_d  = ready_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                sout_d  = STOP_BIT;
                ready_d = 1'b1;
                busy_d  = 1'b0;
                if (din_valid && ready_q) begin
                    shreg_d  = din;
                    bitcnt_d = '0;
                    state_d  = START;
                    sout_d   = START_BIT;
                    ready_d  = 1'b0;
                    busy_d   = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            START: begin
                if (tick_s) begin
                    state_d = DATA;
                    sout_d  = shreg_q[0];
                    shreg_d = {1'b0, shreg_q[DATA_W-1:1]};
                end else begin
                    state_d = START;
                end
            end
            DATA: begin
                if (tick_s) begin
                    if (bitcnt_q == LAST_BIT) begin
                        state_d  = STOP;
                        sout_d   = STOP_BIT;
                        bitcnt_d = '0;
                    end else begin
                        // Line already carries the old bit 0; present the next one.
                        sout_d   = shreg_q[0];
                        shreg_d  = {1'b0, shreg_q[DATA_W-1:1]};
                        bitcnt_d = bitcnt_q + BIT_ONE;
                    end
                end else begin
                    state_d = DATA;
                end
            end
            STOP: begin
                if (tick_s) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    ready_d = 1'b1;
                    busy_d  = 1'b0;
                    sout_d  = STOP_BIT;
                end else begin
                    state_d = STOP;
                end
            end
            default: begin
                state_d  = IDLE;
                sout_d   = STOP_BIT;
                ready_d  = 1'b0;
                busy_d   = 1'b0;
                bitcnt_d = '0;
            end
        endcase
    end

    // State and output registers; reset forces an idle-high line with no frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            shreg_q  <= '0;
            bitcnt_q <= '0;
            sout_q   <= STOP_BIT;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            bitcnt_q <= bitcnt_d;
            sout_q   <= sout_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign din_ready = ready_q;
    assign sout      = sout_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_piso_serial_tx.sv
// Bench for piso_serial_tx: a frame-level reference model checked every cycle
// against two instances (CLKS_PER_BIT 4 and 1), plus literal frame patterns.
module tb_piso_serial_tx;

    localparam int DATA_W = 8;

    logic              clk;
    logic              rst;
    logic [DATA_W-1:0] din_a   [2];
    logic              dv_a    [2];
    logic              ready_a [2];
    logic              sout_a  [2];
    logic              busy_a  [2];
    logic              done_a  [2];

    int n_pass;
    int n_tot;

    // Reference model: cycles elapsed since the accept edge (-1 = no frame).
    int                m_cyc   [2];
    logic [DATA_W-1:0] m_word  [2];
    logic              m_ready [2];
    logic              m_done  [2];

    piso_serial_tx #(.DATA_W(DATA_W), .CLKS_PER_BIT(4)) dut4 (
        .clk(clk), .rst(rst), .din(din_a[0]), .din_valid(dv_a[0]),
        .din_ready(ready_a[0]), .sout(sout_a[0]), .busy(busy_a[0]), .done(done_a[0])
    );

    piso_serial_tx #(.DATA_W(DATA_W), .CLKS_PER_BIT(1)) dut1 (
        .clk(clk), .rst(rst), .din(din_a[1]), .din_valid(dv_a[1]),
        .din_ready(ready_a[1]), .sout(sout_a[1]), .busy(busy_a[1]), .done(done_a[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int cpb_of(input int i);
        return (i == 0) ? 4 : 1;
    endfunction

    // Line level for bit slot idx of a frame carrying word w.
    function automatic logic frame_bit(input int idx, input logic [DATA_W-1:0] w);
        if (idx == 0) return 1'b0;
        else if (idx <= DATA_W) return w[idx-1];
        else return 1'b1;
    endfunction

    always @(posedge clk or posedge rst) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_cyc[i]   <= -1;
                m_ready[i] <= 1'b0;
                m_done[i]  <= 1'b0;
            end else begin
                m_done[i] <= 1'b0;
                if (m_ready[i] && dv_a[i]) begin
                    m_cyc[i]   <= 0;
                    m_word[i]  <= din_a[i];
                    m_ready[i] <= 1'b0;
                end else if (m_cyc[i] >= 0) begin
                    if (m_cyc[i] == (DATA_W + 2) * cpb_of(i) - 1) begin
                        m_cyc[i]   <= -1;
                        m_done[i]  <= 1'b1;
                        m_ready[i] <= 1'b1;
                    end else begin
                        m_cyc[i] <= m_cyc[i] + 1;
                    end
                end else begin
                    m_ready[i] <= 1'b1;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot = n_tot + 1;
        if (act === exp) n_pass = n_pass + 1;
        else $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
    endtask

    task automatic compare_all();
        logic exp_sout;
        for (int i = 0; i < 2; i++) begin
            exp_sout = (m_cyc[i] < 0) ? 1'b1 : frame_bit(m_cyc[i] / cpb_of(i), m_word[i]);
            chk($sformatf("model_sout%0d", i), 32'(sout_a[i]), 32'(exp_sout));
            chk($sformatf("model_busy%0d", i), 32'(busy_a[i]), 32'(m_cyc[i] >= 0));
            chk($sformatf("model_done%0d", i), 32'(done_a[i]), 32'(m_done[i]));
            chk($sformatf("model_ready%0d", i), 32'(ready_a[i]), 32'(m_ready[i]));
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        compare_all();
    endtask

    // Sends one word from IDLE and checks the line against a literal bit pattern.
    task automatic run_frame(input int i, input logic [DATA_W-1:0] w,
                             input logic [9:0] pat, input string tag);
        int cpb;
        int fl;
        cpb = cpb_of(i);
        fl  = (DATA_W + 2) * cpb;
        din_a[i] = w;
        dv_a[i]  = 1'b1;
        cycle();
        dv_a[i] = 1'b0;
        for (int k = 0; k < fl; k++) begin
            chk({tag, "_sout"}, 32'(sout_a[i]), 32'(pat[k / cpb]));
            chk({tag, "_busy"}, 32'(busy_a[i]), 32'd1);
            chk({tag, "_nodone"}, 32'(done_a[i]), 32'd0);
            cycle();
        end
        chk({tag, "_done"}, 32'(done_a[i]), 32'd1);
        chk({tag, "_busy_end"}, 32'(busy_a[i]), 32'd0);
        chk({tag, "_ready_end"}, 32'(ready_a[i]), 32'd1);
    endtask

    initial begin
        n_pass = 0;
        n_tot  = 0;
        for (int i = 0; i < 2; i++) begin
            din_a[i] = 8'h00;
            dv_a[i]  = 1'b0;
        end
        rst = 1'b0;
        #1 rst = 1'b1;

        // Reset state.
        repeat (3) begin
            cycle();
            chk("rst_sout", 32'(sout_a[0]), 32'd1);
            chk("rst_ready", 32'(ready_a[0]), 32'd0);
            chk("rst_busy", 32'(busy_a[1]), 32'd0);
        end
        rst = 1'b0;

        // Idle with no valid: line high, ready after the first edge.
        for (int k = 0; k < 20; k++) begin
            cycle();
            chk("idle_sout", 32'(sout_a[0]), 32'd1);
            chk("idle_busy", 32'(busy_a[0]), 32'd0);
            chk("idle_done", 32'(done_a[0]), 32'd0);
            chk("idle_ready", 32'(ready_a[0]), 32'd1);
        end

        run_frame(0, 8'hA5, 10'b1101001010, "a5");
        cycle();

        // Back-to-back with din_valid held: second accept coincides with done.
        din_a[0] = 8'h3C;
        dv_a[0]  = 1'b1;
        cycle();
        din_a[0] = 8'hC3;
        for (int k = 0; k < 40; k++) begin
            chk("b2b1_sout", 32'(sout_a[0]), 32'(frame_bit(k / 4, 8'h3C)));
            chk("b2b1_ready", 32'(ready_a[0]), 32'd0);
            cycle();
        end
        chk("b2b_done", 32'(done_a[0]), 32'd1);
        chk("b2b_ready", 32'(ready_a[0]), 32'd1);
        chk("b2b_gap_high", 32'(sout_a[0]), 32'd1);
        cycle();
        dv_a[0] = 1'b0;
        for (int k = 0; k < 40; k++) begin
            chk("b2b2_sout", 32'(sout_a[0]), 32'(k < 4 ? 1'b0 : (k < 12 ? 1'b1 : (k < 28 ? 1'b0 : 1'b1))));
            cycle();
        end
        chk("b2b2_done", 32'(done_a[0]), 32'd1);
        cycle();

        // Input changes and valid while busy are ignored.
        din_a[0] = 8'hFF;
        dv_a[0]  = 1'b1;
        cycle();
        din_a[0] = 8'h00;
        for (int k = 0; k < 40; k++) begin
            chk("ff_sout", 32'(sout_a[0]), 32'(k >= 4));
            chk("ff_ready", 32'(ready_a[0]), 32'd0);
            cycle();
        end
        chk("ff_done", 32'(done_a[0]), 32'd1);
        dv_a[0] = 1'b0;
        cycle();
        chk("ff_idle_after", 32'(busy_a[0]), 32'd0);

        // Reset during data bit 3 (cycles 16..19 after accept).
        din_a[0] = 8'h5A;
        dv_a[0]  = 1'b1;
        cycle();
        dv_a[0] = 1'b0;
        for (int k = 0; k < 17; k++) cycle();
        rst = 1'b1;
        #1;
        chk("midrst_sout", 32'(sout_a[0]), 32'd1);
        chk("midrst_busy", 32'(busy_a[0]), 32'd0);
        chk("midrst_done", 32'(done_a[0]), 32'd0);
        chk("midrst_ready", 32'(ready_a[0]), 32'd0);
        repeat (2) begin
            cycle();
            chk("midrst_hold_done", 32'(done_a[0]), 32'd0);
        end
        rst = 1'b0;
        cycle();
        chk("postrst_ready", 32'(ready_a[0]), 32'd1);
        chk("postrst_done", 32'(done_a[0]), 32'd0);
        run_frame(0, 8'h5A, 10'b1010110100, "5a");
        cycle();

        // One clock per bit.
        run_frame(1, 8'h81, 10'b1100000010, "c1_81");
        repeat (3) cycle();

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
